morse_tx: RTL and testbench

MORSE_TX -- requirements
Module: morse_tx

---
 rtl/morse_tx_if.sv | 14 +
 rtl/morse_tx.sv | 112 +++++++++++
 tb/tb_morse_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/morse_tx_if.sv
// Character request / keying bundle between a Morse sender and its client.
interface morse_tx_if;
  logic       start;
  logic [4:0] sym;
  logic [2:0] len;
  logic       key;
  logic       busy;
  logic       done;

  modport master (output start, output sym, output len,
                  input key, input busy, input done);
  modport slave  (input start, input sym, input len,
                  output key, output busy, output done);
endinterface

// File: rtl/morse_tx.sv
// Morse character keyer: times dots, dashes, element spaces and the character gap
// in units of UNIT_CYCLES clocks, with fully registered key/busy/done outputs.
module morse_tx #(
  parameter int UNIT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  morse_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, CGAP} state_t;

  localparam logic [23:0] UNIT_LAST = 24'(UNIT_CYCLES - 1);

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > 3'd5) ? 3'd5 : l;
  endfunction

  // Unit multiplier holds (units - 1): dash = 3 units, dot = 1 unit.
  function automatic logic [1:0] mark_units(input logic dash);
    return dash ? 2'd2 : 2'd0;
  endfunction

  state_t      state;
  logic [23:0] cnt;
  logic [1:0]  mult;
  logic [2:0]  idx;
  logic [4:0]  sym_r;
  logic        key_r;
  logic        busy_r;
  logic        done_r;

  logic [2:0]  len_c;
  logic        last;

  assign len_c = clamp_len(bus.len);
  assign last  = (cnt == 24'd0) && (mult == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 24'd0;
      mult   <= 2'd0;
      idx    <= 3'd0;
      sym_r  <= 5'd0;
      key_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          sym_r  <= bus.sym;
          cnt    <= UNIT_LAST;
          busy_r <= 1'b1;
          if (len_c != 3'd0) begin
            state <= MARK;
            key_r <= 1'b1;
            idx   <= len_c - 3'd1;
            mult  <= mark_units(bus.sym[len_c - 3'd1]);
          end else begin
            state <= CGAP;
            idx   <= 3'd0;
            mult  <= 2'd2;
          end
        end
      end else if (!last) begin
        // Count down within a unit, then step the multiplier; never wraps mid-interval.
        if (cnt == 24'd0) begin
          cnt  <= UNIT_LAST;
          mult <= mult - 2'd1;
        end else begin
          cnt <= cnt - 24'd1;
        end
      end else begin
        cnt <= UNIT_LAST;
        case (state)
          MARK: begin
            key_r <= 1'b0;
            if (idx != 3'd0) begin
              state <= SPACE;
              mult  <= 2'd0;
            end else begin
              state <= CGAP;
              mult  <= 2'd2;
            end
          end
          SPACE: begin
            state <= MARK;
            key_r <= 1'b1;
            idx   <= idx - 3'd1;
            mult  <= mark_units(sym_r[idx - 3'd1]);
          end
          CGAP: begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
          default: begin
            state <= IDLE;
            key_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.key  = key_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: table of known characters, corner sequences and random
// characters, all checked cycle by cycle against an element-level timing model.
module tb_morse_tx;
  localparam int U = 4;

  logic clk = 1'b0;
  logic reset;
  morse_tx_if bus();

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] sym;
    logic [2:0] len;
    int         done_at;
    string      name;
  } vec_t;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Build the expected key waveform from element rules, then run one character.
  task automatic play(input logic [4:0] s, input logic [2:0] l, input bit pre,
                      input bit chain, input logic [4:0] cs, input logic [2:0] cl,
                      input int repulse, input int exp_done, input string name);
    bit q[$];
    int n, t, seen;
    n = (l > 3'd5) ? 5 : int'(l);
    for (int e = n - 1; e >= 0; e--) begin
      repeat ((s[e] ? 3 : 1) * U) q.push_back(1'b1);
      if (e > 0) repeat (U) q.push_back(1'b0);
    end
    repeat (3 * U) q.push_back(1'b0);
    t = q.size();
    seen = 0;
    if (!pre) begin
      @(negedge clk);
      bus.sym = s; bus.len = l; bus.start = 1'b1;
    end
    for (int c = 1; c <= t + 1; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 && seen == 0) seen = c;
      if (c <= t) begin
        check({name, ".key"},  c, 32'(bus.key),  32'(q[c-1]));
        check({name, ".busy"}, c, 32'(bus.busy), 32'd1);
        check({name, ".done"}, c, 32'(bus.done), 32'd0);
      end else begin
        check({name, ".key"},  c, 32'(bus.key),  32'd0);
        check({name, ".busy"}, c, 32'(bus.busy), 32'd0);
        check({name, ".done"}, c, 32'(bus.done), 32'd1);
      end
      bus.start = (c == repulse);
      bus.sym   = 5'($urandom);
      bus.len   = 3'($urandom);
      if (chain && c == t + 1) begin
        bus.start = 1'b1; bus.sym = cs; bus.len = cl;
      end
    end
    if (!chain) begin
      @(negedge clk);
      check({name, ".done_after"}, t + 2, 32'(bus.done), 32'd0);
      check({name, ".busy_after"}, t + 2, 32'(bus.busy), 32'd0);
    end
    if (exp_done != 0) check({name, ".done_cycle"}, t + 1, 32'(seen), 32'(exp_done));
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{5'b00001, 3'd2, 33, "A"};
    tbl[1] = '{5'b00000, 3'd1, 17, "E"};
    tbl[2] = '{5'b10110, 3'd0, 13, "len0"};
    tbl[3] = '{5'b00001, 3'd1, 25, "T"};
    tbl[4] = '{5'b10101, 3'd7, 73, "len7_clamp"};
    tbl[5] = '{5'b00000, 3'd6, 49, "len6_clamp"};

    reset = 1'b1; bus.start = 1'b0; bus.sym = 5'd0; bus.len = 3'd0;
    @(negedge clk);
    check("reset.key",  0, 32'(bus.key),  32'd0);
    check("reset.busy", 0, 32'(bus.busy), 32'd0);
    check("reset.done", 0, 32'(bus.done), 32'd0);

    // Start coincident with reset must be dropped.
    bus.start = 1'b1; bus.sym = 5'b00001; bus.len = 3'd2;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_start.busy", i, 32'(bus.busy), 32'd0);
      check("rst_start.key",  i, 32'(bus.key),  32'd0);
    end

    for (int i = 0; i < 6; i++)
      play(tbl[i].sym, tbl[i].len, 1'b0, 1'b0, 5'd0, 3'd0, 0, tbl[i].done_at, tbl[i].name);

    // Back-to-back: E requested in T's done cycle, key rises the very next cycle.
    play(5'b00001, 3'd1, 1'b0, 1'b1, 5'b00000, 3'd1, 0, 25, "T_chain");
    play(5'b00000, 3'd1, 1'b1, 1'b0, 5'd0, 3'd0, 0, 17, "E_chain");

    play(5'b00001, 3'd2, 1'b0, 1'b0, 5'd0, 3'd0, 6, 33, "A_repulse");

    // Reset in the middle of A's dash.
    @(negedge clk);
    bus.sym = 5'b00001; bus.len = 3'd2; bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("midrst.key_before", 10, 32'(bus.key), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst.key",  10, 32'(bus.key),  32'd0);
    check("midrst.busy", 10, 32'(bus.busy), 32'd0);
    check("midrst.done", 10, 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst.idle_done", i, 32'(bus.done), 32'd0);
      check("midrst.idle_busy", i, 32'(bus.busy), 32'd0);
    end
    play(5'b00001, 3'd2, 1'b0, 1'b0, 5'd0, 3'd0, 0, 33, "A_after_rst");

    for (int i = 0; i < 20; i++)
      play(5'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0, 5'd0, 3'd0, 0, 0, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
